// File: rtl/instr_issue_queue_pkg.sv
// Shared types and widths for the instruction issue queue.
// Contents:
//   OPCODE_W, ADRS_W, IMM_W : field widths of one instruction
//   t_RFadrs                : register-file address type
//   t_instr                 : packed instruction {opcode, src1, src2, dst, imm}
//   instr_gate()            : returns the instruction when valid, all-zero otherwise
package instr_issue_queue_pkg;

  localparam int OPCODE_W = 4;
  localparam int ADRS_W   = 3;
  localparam int IMM_W    = 16;

  typedef logic [ADRS_W-1:0] t_RFadrs;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    t_RFadrs             src1;
    t_RFadrs             src2;
    t_RFadrs             dst;
    logic [IMM_W-1:0]    imm;
  } t_instr;

  // Decode must never see stale storage contents, so fields of an invalid head read as zero.
  function automatic t_instr instr_gate(input logic valid, input t_instr instr);
    t_instr result;
    if (valid) begin
      result = instr;
    end else begin
      result = '0;
    end
    return result;
  endfunction

endpackage

// File: rtl/instr_issue_queue_issue_fifo.sv
// issue_fifo: DEPTH-entry storage of t_instr with wrapping pointers and a
// separately tracked occupancy, plus a synchronous flush.
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-low reset
//   flush          : clears pointers and level at the next edge; push ignored
//   push, wr_data  : write wr_data at the write pointer
//   pop            : advance the read pointer
//   rd_data        : storage slot at the read pointer (unqualified)
//   level          : current occupancy, 0..DEPTH
module issue_fifo
  import instr_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  t_instr                 wr_data,
  input  logic                   pop,
  output t_instr                 rd_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

  t_instr           mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, wr_ptr_s;
  logic [PTR_W-1:0] rd_ptr_r, rd_ptr_s;
  logic [LVL_W-1:0] level_r, level_s;

  // Next-state for pointers and level; DEPTH is a power of two so increments wrap naturally.
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    level_s  = level_r;
    if (flush) begin
      wr_ptr_s = '0;
      rd_ptr_s = '0;
      level_s  = '0;
    end else begin
      if (push) begin
        wr_ptr_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   level_s = level_r + LVL_ONE;
        2'b01:   level_s = level_r - LVL_ONE;
        default: level_s = level_r;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      level_r  <= level_s;
    end
  end

  // Storage write; contents are don't-care until referenced by a valid level.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign level   = level_r;

endmodule

// File: rtl/instr_issue_queue.sv
// instr_issue_queue: buffers host instructions and presents the head to Decode.
// Ports:
//   clock, reset                      : rising-edge clock, async active-low reset
//   in_valid/in_ready                 : host handshake, push = in_valid & in_ready
//   in_opcode/in_src1/in_src2/in_dst/in_imm : host instruction fields
//   stalled                           : Decode did not consume the head this cycle
//   internal_reset                    : Decode flush request, sampled at the edge
//   instv, opcode, src1, src2, dst, imm : head instruction (fields zero when instv=0)
//   level                             : occupancy
//   issued_cnt                        : saturating count of instructions consumed
module instr_issue_queue
  import instr_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE_W-1:0]    in_opcode,
  input  logic [ADRS_W-1:0]      in_src1,
  input  logic [ADRS_W-1:0]      in_src2,
  input  logic [ADRS_W-1:0]      in_dst,
  input  logic [IMM_W-1:0]       in_imm,
  input  logic                   stalled,
  input  logic                   internal_reset,
  output logic                   instv,
  output logic [OPCODE_W-1:0]    opcode,
  output logic [ADRS_W-1:0]      src1,
  output logic [ADRS_W-1:0]      src2,
  output logic [ADRS_W-1:0]      dst,
  output logic [IMM_W-1:0]       imm,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       issued_cnt
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  t_instr           wr_data_s;
  t_instr           rd_data_s;
  t_instr           head_s;
  logic [LVL_W-1:0] level_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] issued_cnt_r;

  assign wr_data_s = '{opcode: in_opcode, src1: in_src1, src2: in_src2,
                       dst: in_dst, imm: in_imm};

  // Ready comes only from registered level, flush and reset; the reset term keeps
  // the host out while the queue is held in reset.
  assign in_ready = reset & (level_s != LVL_FULL) & ~internal_reset;
  assign instv    = (level_s != LVL_ZERO);
  assign push_s   = in_valid & in_ready;
  assign pop_s    = instv & ~stalled;

  issue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (internal_reset),
    .push    (push_s),
    .wr_data (wr_data_s),
    .pop     (pop_s),
    .rd_data (rd_data_s),
    .level   (level_s)
  );

  assign head_s = instr_gate(instv, rd_data_s);
  assign opcode = head_s.opcode;
  assign src1   = head_s.src1;
  assign src2   = head_s.src2;
  assign dst    = head_s.dst;
  assign imm    = head_s.imm;
  assign level  = level_s;

  // Saturating issue counter; a pop during a flush cycle still counts, and only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issued_cnt_r <= '0;
    end else if (pop_s && (issued_cnt_r != CNT_MAX)) begin
      issued_cnt_r <= issued_cnt_r + CNT_ONE;
    end else begin
      issued_cnt_r <= issued_cnt_r;
    end
  end

  assign issued_cnt = issued_cnt_r;

endmodule

// File: tb/tb_instr_issue_queue.sv
module tb_instr_issue_queue;
  import instr_issue_queue_pkg::*;

  logic                clock;
  logic                reset;
  logic                in_valid;
  logic                in_ready, in_ready4;
  logic [OPCODE_W-1:0] in_opcode;
  logic [ADRS_W-1:0]   in_src1, in_src2, in_dst;
  logic [IMM_W-1:0]    in_imm;
  logic                stalled;
  logic                internal_reset;
  logic                instv, instv4;
  logic [OPCODE_W-1:0] opcode, opcode4;
  logic [ADRS_W-1:0]   src1, src2, dst, src1_4, src2_4, dst4;
  logic [IMM_W-1:0]    imm, imm4;
  logic [2:0]          level, level4;
  logic [15:0]         issued_cnt;
  logic [3:0]          issued_cnt4;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  logic [$bits(t_instr)-1:0] head_bits;
  assign head_bits = {opcode, src1, src2, dst, imm};

  instr_issue_queue #(.DEPTH(4), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst),
    .in_imm(in_imm), .stalled(stalled), .internal_reset(internal_reset),
    .instv(instv), .opcode(opcode), .src1(src1), .src2(src2), .dst(dst),
    .imm(imm), .level(level), .issued_cnt(issued_cnt)
  );

  // Narrow-counter build sharing the same stimulus, used for saturation.
  instr_issue_queue #(.DEPTH(4), .CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_opcode(in_opcode), .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst),
    .in_imm(in_imm), .stalled(stalled), .internal_reset(internal_reset),
    .instv(instv4), .opcode(opcode4), .src1(src1_4), .src2(src2_4), .dst(dst4),
    .imm(imm4), .level(level4), .issued_cnt(issued_cnt4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic t_instr mk(input int k);
    t_instr t;
    t.opcode = OPCODE_W'(k);
    t.src1   = ADRS_W'(k + 1);
    t.src2   = ADRS_W'(k + 2);
    t.dst    = ADRS_W'(k + 3);
    t.imm    = IMM_W'(32'h0000_A000 + k);
    return t;
  endfunction

  task automatic drive(input logic v, input t_instr t);
    in_valid  = v;
    in_opcode = t.opcode;
    in_src1   = t.src1;
    in_src2   = t.src2;
    in_dst    = t.dst;
    in_imm    = t.imm;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; stalled = 1'b0; internal_reset = 1'b0;
    drive(1'b0, mk(0));
    tick; tick;
    n_checks++;
    if (instv !== 1'b0 || in_ready !== 1'b0 || level !== 3'd0 || issued_cnt !== 16'd0 || head_bits !== '0) begin
      n_fail++;
      $display("FAIL reset_state: instv=%b in_ready=%b level=%0d cnt=%0d head=%h, want all 0",
               instv, in_ready, level, issued_cnt, head_bits);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single;
    t_instr t;
    t = '{opcode: 4'd3, src1: 3'd1, src2: 3'd2, dst: 3'd5, imm: 16'h00A5};
    drive(1'b1, t);
    tick;
    drive(1'b0, mk(0));
    n_checks++;
    if (instv !== 1'b1 || head_bits !== t || level !== 3'd1) begin
      n_fail++;
      $display("FAIL single_head: instv=%b head=%h level=%0d want 1 %h 1", instv, head_bits, level, t);
    end
    tick;
    exp_cnt = 1;
    n_checks++;
    if (instv !== 1'b0 || issued_cnt !== 16'(exp_cnt) || head_bits !== '0) begin
      n_fail++;
      $display("FAIL single_issue: instv=%b cnt=%0d head=%h want 0 %0d 0", instv, issued_cnt, head_bits, exp_cnt);
    end
  endtask

  task automatic test_stall_fill;
    stalled = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, mk(k));
      tick;
      n_checks++;
      if (head_bits !== mk(1) || instv !== 1'b1 || level !== 3'(k)) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: head=%h level=%0d want %h %0d", k, head_bits, level, mk(1), k);
      end
    end
    drive(1'b0, mk(0));
    n_checks++;
    if (in_ready !== 1'b0 || level !== 3'd4 || issued_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL full: in_ready=%b level=%0d cnt=%0d want 0 4 %0d", in_ready, level, issued_cnt, exp_cnt);
    end
    stalled = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_no_stall_path: got %b want 0", in_ready);
    end
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (head_bits !== mk(k) || instv !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_order_%0d: head=%h want %h", k, head_bits, mk(k));
      end
      tick;
      exp_cnt++;
    end
    n_checks++;
    if (level !== 3'd0 || instv !== 1'b0 || issued_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL drain_end: level=%0d instv=%b cnt=%0d want 0 0 %0d", level, instv, issued_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back;
    stalled = 1'b1;
    drive(1'b1, mk(20)); tick;
    drive(1'b1, mk(21)); tick;
    stalled = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, mk(22 + k));
      #1;
      n_checks++;
      if (head_bits !== mk(20 + k) || in_ready !== 1'b1 || level !== 3'd2) begin
        n_fail++;
        $display("FAIL b2b_%0d: head=%h ready=%b level=%0d want %h 1 2", k, head_bits, in_ready, level, mk(20 + k));
      end
      tick;
      exp_cnt++;
    end
    drive(1'b0, mk(0));
    n_checks++;
    if (level !== 3'd2 || issued_cnt !== 16'(exp_cnt) || head_bits !== mk(30)) begin
      n_fail++;
      $display("FAIL b2b_end: level=%0d cnt=%0d head=%h want 2 %0d %h", level, issued_cnt, head_bits, exp_cnt, mk(30));
    end
    tick; tick;
    exp_cnt += 2;
    n_checks++;
    if (level !== 3'd0 || issued_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL b2b_drain: level=%0d cnt=%0d want 0 %0d", level, issued_cnt, exp_cnt);
    end
  endtask

  task automatic test_flush;
    stalled = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, mk(40 + k));
      tick;
    end
    drive(1'b1, mk(50));
    internal_reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || level !== 3'd3) begin
      n_fail++;
      $display("FAIL flush_ready: in_ready=%b level=%0d want 0 3", in_ready, level);
    end
    tick;
    internal_reset = 1'b0;
    drive(1'b0, mk(0));
    n_checks++;
    if (level !== 3'd0 || instv !== 1'b0 || head_bits !== '0 || issued_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL flush_clear: level=%0d instv=%b head=%h cnt=%0d want 0 0 0 %0d",
               level, instv, head_bits, issued_cnt, exp_cnt);
    end
    stalled = 1'b0;
    drive(1'b1, mk(60));
    tick;
    drive(1'b0, mk(0));
    n_checks++;
    if (instv !== 1'b1 || head_bits !== mk(60)) begin
      n_fail++;
      $display("FAIL flush_next_push: instv=%b head=%h want 1 %h", instv, head_bits, mk(60));
    end
    tick;
    exp_cnt++;
    n_checks++;
    if (level !== 3'd0 || issued_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL flush_next_issue: level=%0d cnt=%0d want 0 %0d", level, issued_cnt, exp_cnt);
    end
    // Flush with an unstalled head: the pop in that cycle still counts.
    stalled = 1'b1;
    drive(1'b1, mk(61)); tick;
    drive(1'b0, mk(0));
    stalled = 1'b0;
    internal_reset = 1'b1;
    tick;
    internal_reset = 1'b0;
    exp_cnt++;
    n_checks++;
    if (level !== 3'd0 || issued_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL flush_pop_counts: level=%0d cnt=%0d want 0 %0d", level, issued_cnt, exp_cnt);
    end
  endtask

  task automatic test_async_reset;
    stalled = 1'b1;
    drive(1'b1, mk(70)); tick;
    drive(1'b1, mk(71)); tick;
    drive(1'b0, mk(0));
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (instv !== 1'b0 || level !== 3'd0 || issued_cnt !== 16'd0 || issued_cnt4 !== 4'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: instv=%b level=%0d cnt=%0d cnt4=%0d ready=%b want 0 0 0 0 0",
               instv, level, issued_cnt, issued_cnt4, in_ready);
    end
    reset = 1'b1;
    #1;
    exp_cnt = 0;
    n_checks++;
    if (in_ready !== 1'b1 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL async_release: ready=%b level=%0d want 1 0", in_ready, level);
    end
  endtask

  task automatic test_saturation;
    int e4;
    stalled = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, mk(k));
      tick;
      e4 = (k - 1 > 15) ? 15 : k - 1;
      n_checks++;
      if (issued_cnt !== 16'(k - 1) || issued_cnt4 !== 4'(e4) || level4 !== 3'd1) begin
        n_fail++;
        $display("FAIL sat_%0d: cnt=%0d cnt4=%0d level4=%0d want %0d %0d 1", k, issued_cnt, issued_cnt4, level4, k - 1, e4);
      end
    end
    drive(1'b0, mk(0));
    tick;
    n_checks++;
    if (issued_cnt !== 16'd20 || issued_cnt4 !== 4'd15 || instv4 !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_end: cnt=%0d cnt4=%0d instv4=%b want 20 15 0", issued_cnt, issued_cnt4, instv4);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stall_fill;
    test_back_to_back;
    test_flush;
    test_async_reset;
    test_saturation;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
Producer-side front end that feeds instructions into the Decode stage.
- Accepts instructions from the external host over a valid/ready handshake and buffers them in a small FIFO.
- Presents the head entry to Decode as opcode/instv/src1/src2/dst/imm.
- Holds the head while Decode reports stalled, and flushes all buffered entries when Decode raises internal_reset.

Parameters:
DEPTH, 4, number of buffered instructions (power of 2, >=2)
OPCODE_W, 4, opcode field width
ADRS_W, 3, register-file address width (matches t_RFadrs)
IMM_W, 16, immediate field width
CNT_W, 16, width of issued-instruction counter

Ports:
clock  in  1  single clock, rising-edge
reset  in  1  asynchronous, active-low (0 = reset)
in_valid  in  1  host offers an instruction
in_ready  out  1  queue can accept this cycle
in_opcode  in  OPCODE_W  host opcode
in_src1  in  ADRS_W  host source 1
in_src2  in  ADRS_W  host source 2
in_dst  in  ADRS_W  host destination
in_imm  in  IMM_W  host immediate
stalled  in  1  from Decode: head not consumed this cycle
internal_reset  in  1  from Decode: synchronous flush request
instv  out  1  head instruction valid, to Decode
opcode  out  OPCODE_W  head opcode
src1  out  ADRS_W  head src1
src2  out  ADRS_W  head src2
dst  out  ADRS_W  head dst
imm  out  IMM_W  head immediate
level  out  clog2(DEPTH)+1  current occupancy
issued_cnt  out  CNT_W  instructions consumed by Decode, saturating

Behaviour:
Reset
- While reset=0: pointers, level and issued_cnt are 0. instv=0, in_ready=0, all fields 0.
- First cycle after release: in_ready=1.

Handshakes
- push = in_valid & in_ready.
- pop = instv & ~stalled.
- in_ready = (level != DEPTH) & ~internal_reset.
- in_ready depends only on registered state and internal_reset; it has no path from stalled.

Outputs
- instv = (level != 0).
- Fields come from the storage slot at the read pointer.
- Fields are forced to 0 whenever instv=0.

Latency
- An instruction pushed at edge N into an empty queue appears with instv=1 in the cycle after edge N.
- There is no bypass.

Simultaneous events
- Push and pop in the same cycle: level is unchanged and both pointers advance.
- Push when full cannot occur, because in_ready=0 at level=DEPTH.
- Pop when empty cannot occur, because instv=0 at level=0.

Stall
- While stalled=1: read pointer, head fields and instv hold.
- Pushes continue until full.

Flush (internal_reset=1, sampled at the edge)
- Read pointer, write pointer and level clear to 0.
- Any push attempted that cycle is refused (in_ready=0).
- A pop in that cycle still counts in issued_cnt only if stalled=0.
- Next cycle: instv=0.
- Storage contents need not clear.

Pointers
- Wrap modulo DEPTH.
- level is tracked separately from the pointers, so full and empty are unambiguous.

issued_cnt
- Increments on each pop.
- Saturates at 2^CNT_W-1.
- Is not cleared by internal_reset, only by reset.

Asynchronous reset
- Reset asserted mid-operation clears state immediately, independent of clock.

Decomposition:
- OPCODE_W, ADRS_W, IMM_W and an instruction struct type t_instr {opcode, src1, src2, dst, imm} go in the shared package alongside t_RFadrs.
- One sub-module, issue_fifo: generic DEPTH x t_instr storage with pointers, level and flush input.
- The top adds the handshake logic, output zero-forcing and issued_cnt.

Test Plan:
1. Reset, then push {opcode=3, src1=1, src2=2, dst=5, imm=16'h00A5} with stalled=0 -> in the next cycle instv=1 and fields match; the following cycle instv=0 and issued_cnt=1.
2. Hold stalled=1 and push 4 instructions -> level=4, in_ready=0, head remains instr#1 throughout. Drop stalled -> instrs 1..4 issue in order on 4 consecutive cycles, then level=0.
3. Keep level=2 with push and pop every cycle for 10 cycles -> level stays 2, order preserved across pointer wrap, issued_cnt increases by 10.
4. With level=3, assert internal_reset for 1 cycle while in_valid=1 -> that push is refused (in_ready=0), next cycle level=0 and instv=0, and the next push is issued normally.
5. Assert reset=0 asynchronously between clock edges with level=2 -> instv, level and issued_cnt are 0 immediately. After release, in_ready=1.
6. Preload issued_cnt near saturation (CNT_W=4 build), issue 20 instructions -> issued_cnt holds at 15.
